// File: rtl/pwm_pkg.sv
// Shared definitions for the breathing-LED PWM sequencer: state encodings
// and the default timebase width.
package pwm_pkg;

    localparam int PWM_CNT_W = 8;
    localparam int CNT_MAX   = (1 << PWM_CNT_W) - 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RAMP_UP = 3'd1,
        ST_HOLD_HI = 3'd2,
        ST_RAMP_DN = 3'd3,
        ST_HOLD_LO = 3'd4
    } pwm_state_e;

endpackage

// File: rtl/pwm_step_sat.sv
// Combinational duty stepper: duty +/- step, clamped to [duty_min, duty_max].
// A step of zero is treated as one so a ramp always makes progress.
module pwm_step_sat
    import pwm_pkg::*;
#(
    parameter int CNT_W = PWM_CNT_W
) (
    input  logic [CNT_W-1:0] duty,
    input  logic [CNT_W-1:0] step,
    input  logic [CNT_W-1:0] duty_min,
    input  logic [CNT_W-1:0] duty_max,
    output logic [CNT_W-1:0] up_val,
    output logic [CNT_W-1:0] dn_val
);

    logic [CNT_W-1:0] step_eff;
    logic [CNT_W:0]   sum;
    logic [CNT_W:0]   diff;

    always_comb begin
        step_eff = (step == '0) ? CNT_W'(1) : step;
        // One extra bit so the sum cannot wrap and the difference exposes a borrow.
        sum      = {1'b0, duty} + {1'b0, step_eff};
        diff     = {1'b0, duty} - {1'b0, step_eff};
        up_val   = (sum > {1'b0, duty_max}) ? duty_max : sum[CNT_W-1:0];
        dn_val   = (diff[CNT_W] || (diff[CNT_W-1:0] < duty_min)) ? duty_min : diff[CNT_W-1:0];
    end

endmodule

// File: rtl/pwm_breath_ctrl.sv
// Breathing-LED sequencer: drives an external up counter as the PWM timebase
// and ramps the duty between min and max, holding at each end.
module pwm_breath_ctrl
    import pwm_pkg::*;
#(
    parameter int CNT_W   = PWM_CNT_W,
    parameter int PRESC_W = 16,
    parameter int HOLD_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CNT_W-1:0]   cfg_duty_min,
    input  logic [CNT_W-1:0]   cfg_duty_max,
    input  logic [CNT_W-1:0]   cfg_step,
    input  logic [PRESC_W-1:0] cfg_prescale,
    input  logic [HOLD_W-1:0]  cfg_hold,
    output logic               cfg_err,
    input  logic [CNT_W-1:0]   cnt_value,
    output logic               cnt_enable,
    output logic               cnt_reset,
    output logic               pwm_out,
    output logic [CNT_W-1:0]   duty,
    output logic [2:0]         state,
    output logic               period_tick
);

    localparam logic [CNT_W-1:0] PERIOD_LAST = {CNT_W{1'b1}};

    pwm_state_e         state_q, state_d;
    logic [CNT_W-1:0]   duty_q, duty_d;
    logic               pwm_q, pwm_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               stop_pend_q, stop_pend_d;
    logic               cfg_err_q, cfg_err_d;
    logic [CNT_W-1:0]   min_q, min_d;
    logic [CNT_W-1:0]   max_q, max_d;
    logic [CNT_W-1:0]   step_q, step_d;
    logic [PRESC_W-1:0] cfg_presc_q, cfg_presc_d;
    logic [HOLD_W-1:0]  cfg_hold_q, cfg_hold_d;

    logic [CNT_W-1:0]   up_val;
    logic [CNT_W-1:0]   dn_val;
    logic               cfg_take;
    logic               is_active;

    pwm_step_sat #(.CNT_W(CNT_W)) u_step (
        .duty     (duty_q),
        .step     (step_q),
        .duty_min (min_q),
        .duty_max (max_q),
        .up_val   (up_val),
        .dn_val   (dn_val)
    );

    assign cfg_ready   = (state_q == ST_IDLE);
    assign cnt_reset   = (state_q == ST_IDLE);
    assign cnt_enable  = (state_q != ST_IDLE);
    assign period_tick = cnt_enable && (cnt_value == PERIOD_LAST);
    assign pwm_out     = pwm_q;
    assign duty        = duty_q;
    assign state       = state_q;
    assign cfg_err     = cfg_err_q;

    always_comb begin
        state_d     = state_q;
        duty_d      = duty_q;
        presc_d     = presc_q;
        hold_d      = hold_q;
        stop_pend_d = stop_pend_q;
        min_d       = min_q;
        max_d       = max_q;
        step_d      = step_q;
        cfg_presc_d = cfg_presc_q;
        cfg_hold_d  = cfg_hold_q;
        cfg_err_d   = 1'b0;

        is_active = (state_q inside {ST_RAMP_UP, ST_HOLD_HI, ST_RAMP_DN, ST_HOLD_LO});
        pwm_d     = is_active && (cnt_value < duty_q);
        cfg_take  = cfg_valid && cfg_ready && (cfg_duty_min <= cfg_duty_max);

        if (cfg_valid && cfg_ready) begin
            if (cfg_duty_min > cfg_duty_max) begin
                cfg_err_d = 1'b1;
            end else begin
                min_d       = cfg_duty_min;
                max_d       = cfg_duty_max;
                step_d      = cfg_step;
                cfg_presc_d = cfg_prescale;
                cfg_hold_d  = cfg_hold;
            end
        end

        if (state_q == ST_IDLE) begin
            // A simultaneous stop cancels the start; a simultaneous config wins.
            if (start && !stop) begin
                state_d     = ST_RAMP_UP;
                duty_d      = cfg_take ? cfg_duty_min : min_q;
                presc_d     = '0;
                hold_d      = '0;
                stop_pend_d = 1'b0;
            end
        end else if (!is_active) begin
            state_d = ST_IDLE;
            duty_d  = '0;
        end else begin
            if (stop) begin
                stop_pend_d = 1'b1;
            end
            if (period_tick) begin
                if (stop_pend_q || stop) begin
                    state_d     = ST_IDLE;
                    duty_d      = '0;
                    presc_d     = '0;
                    hold_d      = '0;
                    stop_pend_d = 1'b0;
                end else begin
                    // Turning at an end always applies the first step of the new
                    // direction, either immediately (no hold) or on leaving the hold.
                    case (state_q)
                        ST_RAMP_UP: begin
                            if (presc_q == cfg_presc_q) begin
                                presc_d = '0;
                                if (duty_q == max_q) begin
                                    if (cfg_hold_q == '0) begin
                                        state_d = ST_RAMP_DN;
                                        duty_d  = dn_val;
                                    end else begin
                                        state_d = ST_HOLD_HI;
                                        hold_d  = '0;
                                    end
                                end else begin
                                    duty_d = up_val;
                                end
                            end else begin
                                presc_d = presc_q + PRESC_W'(1);
                            end
                        end
                        ST_RAMP_DN: begin
                            if (presc_q == cfg_presc_q) begin
                                presc_d = '0;
                                if (duty_q == min_q) begin
                                    if (cfg_hold_q == '0) begin
                                        state_d = ST_RAMP_UP;
                                        duty_d  = up_val;
                                    end else begin
                                        state_d = ST_HOLD_LO;
                                        hold_d  = '0;
                                    end
                                end else begin
                                    duty_d = dn_val;
                                end
                            end else begin
                                presc_d = presc_q + PRESC_W'(1);
                            end
                        end
                        ST_HOLD_HI: begin
                            if (hold_q == cfg_hold_q - HOLD_W'(1)) begin
                                presc_d = '0;
                                hold_d  = '0;
                                // With min == max there is nothing to ramp; go straight to the other hold.
                                if (duty_q == min_q) begin
                                    state_d = ST_HOLD_LO;
                                end else begin
                                    state_d = ST_RAMP_DN;
                                    duty_d  = dn_val;
                                end
                            end else begin
                                hold_d = hold_q + HOLD_W'(1);
                            end
                        end
                        ST_HOLD_LO: begin
                            if (hold_q == cfg_hold_q - HOLD_W'(1)) begin
                                presc_d = '0;
                                hold_d  = '0;
                                if (duty_q == max_q) begin
                                    state_d = ST_HOLD_HI;
                                end else begin
                                    state_d = ST_RAMP_UP;
                                    duty_d  = up_val;
                                end
                            end else begin
                                hold_d = hold_q + HOLD_W'(1);
                            end
                        end
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            duty_q      <= '0;
            pwm_q       <= 1'b0;
            presc_q     <= '0;
            hold_q      <= '0;
            stop_pend_q <= 1'b0;
            cfg_err_q   <= 1'b0;
            min_q       <= '0;
            max_q       <= '0;
            step_q      <= '0;
            cfg_presc_q <= '0;
            cfg_hold_q  <= '0;
        end else begin
            state_q     <= state_d;
            duty_q      <= duty_d;
            pwm_q       <= pwm_d;
            presc_q     <= presc_d;
            hold_q      <= hold_d;
            stop_pend_q <= stop_pend_d;
            cfg_err_q   <= cfg_err_d;
            min_q       <= min_d;
            max_q       <= max_d;
            step_q      <= step_d;
            cfg_presc_q <= cfg_presc_d;
            cfg_hold_q  <= cfg_hold_d;
        end
    end

endmodule

// File: tb/tb_pwm_breath_ctrl.sv
// Bench for pwm_breath_ctrl: external 8-bit counter model, per-period duty
// scoreboard, table of ramp scenarios and hand-written corner sequences.
module tb_pwm_breath_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic        stop;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [7:0]  cfg_duty_min;
    logic [7:0]  cfg_duty_max;
    logic [7:0]  cfg_step;
    logic [15:0] cfg_prescale;
    logic [7:0]  cfg_hold;
    logic        cfg_err;
    logic [7:0]  cnt_value;
    logic        cnt_enable;
    logic        cnt_reset;
    logic        pwm_out;
    logic [7:0]  duty;
    logic [2:0]  state;
    logic        period_tick;

    pwm_breath_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_duty_min (cfg_duty_min),
        .cfg_duty_max (cfg_duty_max),
        .cfg_step     (cfg_step),
        .cfg_prescale (cfg_prescale),
        .cfg_hold     (cfg_hold),
        .cfg_err      (cfg_err),
        .cnt_value    (cnt_value),
        .cnt_enable   (cnt_enable),
        .cnt_reset    (cnt_reset),
        .pwm_out      (pwm_out),
        .duty         (duty),
        .state        (state),
        .period_tick  (period_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External timebase counter
    always_ff @(posedge clk) begin
        if (cnt_reset)       cnt_value <= 8'd0;
        else if (cnt_enable) cnt_value <= cnt_value + 8'd1;
    end

    typedef struct packed {
        logic [7:0]        dmin;
        logic [7:0]        dmax;
        logic [7:0]        step;
        logic [15:0]       presc;
        logic [7:0]        hold;
        logic              together;
        logic [3:0]        nper;
        logic [0:11][7:0]  duties;
        logic [0:11][2:0]  states;
    } scen_t;

    typedef struct {
        logic [7:0] duty;
        logic [2:0] st;
    } exp_t;

    scen_t tbl [5];
    exp_t  sb_q [$];

    int    n_checks = 0;
    int    n_pass   = 0;
    bit    mon_en   = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Per-period monitor: duty/state at each period start, pwm high count at each period end.
    initial begin
        bit         prev_active = 1'b0;
        logic [7:0] prev_cnt    = 8'd0;
        int         hi_acc      = 0;
        bit         have_exp    = 1'b0;
        int         cur_exp     = 0;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (prev_active) begin
                    hi_acc = hi_acc + int'(pwm_out);
                    if (prev_cnt == 8'hFF) begin
                        if (have_exp) chk("pwm_high_count", hi_acc, cur_exp);
                        hi_acc = 0;
                    end
                end
                if (state != 3'd0 && cnt_value == 8'd0) begin
                    if (sb_q.size() > 0) begin
                        e = sb_q.pop_front();
                        chk("period_duty", int'(duty), int'(e.duty));
                        chk("period_state", int'(state), int'(e.st));
                        cur_exp  = int'(e.duty);
                        have_exp = 1'b1;
                    end else begin
                        have_exp = 1'b0;
                    end
                end
            end else begin
                hi_acc   = 0;
                have_exp = 1'b0;
            end
            prev_active = (state != 3'd0);
            prev_cnt    = cnt_value;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [7:0] mn, input logic [7:0] mx, input logic [7:0] st,
                           input logic [15:0] ps, input logic [7:0] hd);
        cfg_duty_min = mn;
        cfg_duty_max = mx;
        cfg_step     = st;
        cfg_prescale = ps;
        cfg_hold     = hd;
    endtask

    task automatic load_cfg(input logic [7:0] mn, input logic [7:0] mx, input logic [7:0] st,
                            input logic [15:0] ps, input logic [7:0] hd);
        set_cfg(mn, mx, st, ps, hd);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push_exp(input logic [7:0] d, input logic [2:0] s);
        exp_t e;
        e.duty = d;
        e.st   = s;
        sb_q.push_back(e);
    endtask

    task automatic wait_sb_empty(input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("scoreboard_drained", sb_q.size(), 0);
        sb_q.delete();
        #1;
    endtask

    task automatic stop_and_idle();
        int n = 0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        while (state != 3'd0 && n < 600) begin
            tick();
            n++;
        end
        chk("idle_after_stop", int'(state), 0);
        chk("duty_after_stop", int'(duty), 0);
        chk("cnt_reset_in_idle", int'(cnt_reset), 1);
    endtask

    initial begin
        int n;
        bit busy_ok;

        tbl[0] = '{dmin: 8'd0, dmax: 8'd8, step: 8'd4, presc: 16'd0, hold: 8'd1, together: 1'b0, nper: 4'd10,
                   duties: {8'd0, 8'd4, 8'd8, 8'd8, 8'd4, 8'd0, 8'd0, 8'd4, 8'd8, 8'd8, 8'd0, 8'd0},
                   states: {3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd3, 3'd4, 3'd1, 3'd1, 3'd2, 3'd0, 3'd0}};
        tbl[1] = '{dmin: 8'd0, dmax: 8'd250, step: 8'd100, presc: 16'd0, hold: 8'd0, together: 1'b1, nper: 4'd8,
                   duties: {8'd0, 8'd100, 8'd200, 8'd250, 8'd150, 8'd50, 8'd0, 8'd100, 8'd0, 8'd0, 8'd0, 8'd0},
                   states: {3'd1, 3'd1, 3'd1, 3'd1, 3'd3, 3'd3, 3'd3, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0}};
        tbl[2] = '{dmin: 8'd10, dmax: 8'd20, step: 8'd0, presc: 16'd2, hold: 8'd2, together: 1'b0, nper: 4'd9,
                   duties: {8'd10, 8'd10, 8'd10, 8'd11, 8'd11, 8'd11, 8'd12, 8'd12, 8'd12, 8'd0, 8'd0, 8'd0},
                   states: {3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0}};
        tbl[3] = '{dmin: 8'd5, dmax: 8'd5, step: 8'd3, presc: 16'd0, hold: 8'd1, together: 1'b0, nper: 4'd5,
                   duties: {8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
                   states: {3'd1, 3'd2, 3'd4, 3'd2, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}};
        tbl[4] = '{dmin: 8'd0, dmax: 8'd2, step: 8'd2, presc: 16'd1, hold: 8'd2, together: 1'b0, nper: 4'd11,
                   duties: {8'd0, 8'd0, 8'd2, 8'd2, 8'd2, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0, 8'd2, 8'd0},
                   states: {3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4, 3'd1, 3'd0}};

        reset     = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        cfg_valid = 1'b0;
        set_cfg(8'd0, 8'd0, 8'd0, 16'd0, 8'd0);
        repeat (3) tick();

        chk("rst_state", int'(state), 0);
        chk("rst_duty", int'(duty), 0);
        chk("rst_pwm", int'(pwm_out), 0);
        chk("rst_cnt_reset", int'(cnt_reset), 1);
        chk("rst_cnt_enable", int'(cnt_enable), 0);
        chk("rst_cfg_ready", int'(cfg_ready), 1);
        chk("rst_cfg_err", int'(cfg_err), 0);
        reset  = 1'b0;
        mon_en = 1'b1;
        tick();

        // Bad config is rejected and the earlier one stays in force.
        load_cfg(8'd7, 8'd30, 8'd5, 16'd0, 8'd0);
        chk("good_cfg_err", int'(cfg_err), 0);
        load_cfg(8'd9, 8'd3, 8'd50, 16'd3, 8'd9);
        chk("bad_cfg_err_pulse", int'(cfg_err), 1);
        tick();
        chk("bad_cfg_err_cleared", int'(cfg_err), 0);
        push_exp(8'd7, 3'd1);
        push_exp(8'd12, 3'd1);
        push_exp(8'd17, 3'd1);
        pulse_start();
        wait_sb_empty(4 * 256);
        stop_and_idle();
        $display("seq retained_cfg: min=7 max=30 step=5 after rejected min=9 max=3");

        // Stop mid-period takes effect only at the period boundary.
        push_exp(8'd7, 3'd1);
        pulse_start();
        n = 0;
        while (cnt_value != 8'd10 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("reached_cnt10", int'(cnt_value), 10);
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop    = 1'b0;
        busy_ok = 1'b1;
        n       = 0;
        @(negedge clk);
        while (cnt_value != 8'hFF && n < 300) begin
            if (state == 3'd0) busy_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        chk("busy_until_period_end", int'(busy_ok), 1);
        chk("busy_at_cnt255", int'(state != 3'd0), 1);
        chk("period_tick_at_255", int'(period_tick), 1);
        @(posedge clk);
        #1;
        chk("idle_after_boundary", int'(state), 0);
        chk("cnt_reset_after_stop", int'(cnt_reset), 1);
        chk("duty_zero_after_stop", int'(duty), 0);
        chk("period_tick_idle", int'(period_tick), 0);
        chk("stop_sb_drained", sb_q.size(), 0);
        $display("seq stop_mid_period: stop at cnt=10, idle after cnt=255");

        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < int'(tbl[i].nper); k++) push_exp(tbl[i].duties[k], tbl[i].states[k]);
            chk("cfg_ready_idle", int'(cfg_ready), 1);
            set_cfg(tbl[i].dmin, tbl[i].dmax, tbl[i].step, tbl[i].presc, tbl[i].hold);
            cfg_valid = 1'b1;
            start     = tbl[i].together;
            tick();
            cfg_valid = 1'b0;
            start     = 1'b0;
            chk("cfg_err_valid_cfg", int'(cfg_err), 0);
            if (!tbl[i].together) pulse_start();
            chk("cfg_ready_busy", int'(cfg_ready), 0);
            chk("cnt_enable_busy", int'(cnt_enable), 1);
            wait_sb_empty(int'(tbl[i].nper) * 256 + 64);
            stop_and_idle();
            $display("scenario %0d: min=%0d max=%0d step=%0d presc=%0d hold=%0d periods=%0d",
                     i, tbl[i].dmin, tbl[i].dmax, tbl[i].step, tbl[i].presc, tbl[i].hold, tbl[i].nper);
        end

        // Start and stop together in IDLE: nothing happens.
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        repeat (2) tick();
        chk("start_stop_stays_idle", int'(state), 0);
        chk("start_stop_cnt_enable", int'(cnt_enable), 0);
        $display("seq start_and_stop: remains idle");

        // Asynchronous reset in the middle of RAMP_UP with the LED high.
        mon_en = 1'b0;
        pulse_start();
        n = 0;
        while (pwm_out != 1'b1 && n < 1200) begin
            @(negedge clk);
            n++;
        end
        chk("pwm_seen_high", int'(pwm_out), 1);
        chk("ramp_up_before_reset", int'(state), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_pwm", int'(pwm_out), 0);
        chk("async_rst_cnt_reset", int'(cnt_reset), 1);
        chk("async_rst_state", int'(state), 0);
        chk("async_rst_duty", int'(duty), 0);
        tick();
        chk("counter_cleared", int'(cnt_value), 0);
        reset = 1'b0;
        tick();
        chk("idle_after_reset", int'(state), 0);
        $display("seq async_reset: outputs returned to reset values");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pwm_breath_ctrl.md
Name: pwm_breath_ctrl

Overview:
Sequencer that drives the team's 8-bit up counter (cnt_enable / cnt_reset out, cnt_value in) as the PWM timebase and produces a "breathing" LED waveform. It ramps duty between a configured min and max, holds at each end, and repeats. It sits between the register/config interface and the LED pin. The counter's own synchronous reset is driven from this block.

Parameters:
CNT_W, 8, counter/duty width; PWM period = 2^CNT_W enabled clocks
PRESC_W, 16, width of the period prescaler (periods per duty step, minus 1)
HOLD_W, 8, width of the hold-period counter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  1-cycle pulse; begin sequence (ignored unless IDLE)
stop  in  1  1-cycle pulse; return to IDLE at the next period boundary
cfg_valid  in  1  config handshake valid
cfg_ready  out  1  high only in IDLE
cfg_duty_min  in  CNT_W  lower duty bound
cfg_duty_max  in  CNT_W  upper duty bound
cfg_step  in  CNT_W  duty increment per step; 0 treated as 1
cfg_prescale  in  PRESC_W  PWM periods per step, minus 1
cfg_hold  in  HOLD_W  periods held at max and at min; 0 = no hold
cfg_err  out  1  1-cycle pulse: config rejected
cnt_value  in  CNT_W  counter output
cnt_enable  out  1  counter enable
cnt_reset  out  1  counter synchronous clear
pwm_out  out  1  LED drive, registered
duty  out  CNT_W  current duty
state  out  3  FSM state, for debug
period_tick  out  1  combinational: cnt_enable && cnt_value == 2^CNT_W-1

Behaviour:
- Async reset state: IDLE, duty=0, pwm_out=0, cnt_enable=0, cnt_reset=1, cfg_err=0, all config registers 0, prescale and hold counters 0.
- States: IDLE=0, RAMP_UP=1, HOLD_HI=2, RAMP_DN=3, HOLD_LO=4.
- IDLE outputs: cnt_reset=1, cnt_enable=0, pwm_out=0, cfg_ready=1. In every other state: cnt_reset=0, cnt_enable=1.
- Config acceptance:
  - cfg_valid && cfg_ready latches all cfg_* fields in that cycle.
  - If cfg_duty_min > cfg_duty_max, nothing is latched and cfg_err pulses for 1 cycle.
- Start: start in IDLE -> RAMP_UP on the next edge; duty <= min; prescale counter <= 0. The counter then reads 0 on the first enabled cycle, so periods are aligned.
- start && cfg_valid in the same cycle: the config is latched and the start uses the new config.
- PWM: pwm_out <= (cnt_value < duty) every cycle outside IDLE; 1 clk latency. duty=0 gives always low; duty=255 gives high for 255 of 256 clocks.
- Steps:
  - All duty and hold updates occur only on period_tick, so new duty takes effect from cnt_value=0.
  - The prescale counter increments on each period_tick. When it equals cfg_prescale, it clears and a step occurs.
- RAMP_UP step: duty <= min(duty + step, max), computed at CNT_W+1 bits with no wrap.
  - If duty was already == max at the step, go to HOLD_HI with hold counter <= 0.
  - If cfg_hold=0, go directly to RAMP_DN instead.
- HOLD_HI / HOLD_LO: the hold counter increments per period_tick (not prescaled). At cfg_hold-1 it goes to RAMP_DN / RAMP_UP respectively.
- RAMP_DN step: duty <= max(duty - step, min), saturating. At duty == min on a step, go to HOLD_LO (or RAMP_UP if cfg_hold=0).
- min == max: ramps degenerate to hold-only; the FSM alternates HOLD_HI and HOLD_LO.
- Stop:
  - stop sets a pending flag. At the next period_tick: IDLE, duty <= 0, flag cleared.
  - stop in IDLE is ignored.
  - start and stop in the same cycle: stop wins, start is ignored.
- Reset mid-operation: immediate return to reset values. Because cnt_reset=1, the counter clears on the next clk edge.

Decomposition:
- Shared package pwm_pkg: state encodings (ST_IDLE..ST_HOLD_LO), CNT_W default, and a CNT_MAX constant.
- One natural sub-module, pwm_step_sat: combinational saturating add/sub of duty by step, clamped to [min, max].
- The counter itself stays an external instance wired at top level.

Test Plan:
1. Reset asserted mid-RAMP_UP -> same cycle (async): pwm_out=0, cnt_reset=1, state=0, duty=0.
2. cfg min=0, max=8, step=4, prescale=0, hold=1; start -> duty sequence per period: 0, 4, 8, 8 (HOLD_HI), 4, 0, 0 (HOLD_LO), 4…; pwm_out high for exactly duty clocks per 256.
3. step=100, max=250, prescale=0 -> duty 0, 100, 200, 250 (saturated), no wrap; ramp down 150, 50, 0.
4. cfg min=9, max=3 -> cfg_err pulse; the previous config is retained (check by start).
5. stop while cnt_value=10 -> state stays non-IDLE until cnt_value=255; IDLE on the next edge; cnt_reset=1.
6. start and stop same cycle in IDLE -> remains IDLE. prescale=2 -> duty changes every 3rd period_tick. step=0 behaves as step=1.
